// File: rtl/audio_pkg.sv
// Shared constants for the audio frame buffer: bus page offsets, STATUS layout, overrun width.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package audio_pkg;

  // Host bus segment and page offsets relative to the block's base page
  localparam logic [7:0]  IOMEM_SEG      = 8'h03;
  localparam logic [15:0] PG_OFS_STATUS  = 16'h0200;
  localparam logic [15:0] PG_OFS_CLEAR   = 16'h0300;
  localparam logic [15:0] PG_OFS_INPUT   = 16'h0400;

  // STATUS word layout
  localparam int ST_HOST_WR   = 0;
  localparam int ST_RUN       = 1;
  localparam int ST_BUSY      = 2;
  localparam int ST_FRAME_LSB = 8;
  localparam int ST_OVF_LSB   = 16;

  // Overrun counter width; the counter saturates at its all-ones value
  localparam int OVF_W = 8;

  typedef enum logic [1:0] {
    PG_NONE,
    PG_STATUS,
    PG_CLEAR,
    PG_INPUT
  } page_e;

  // Increment that sticks at the maximum value instead of wrapping
  function automatic logic [OVF_W-1:0] sat_inc(input logic [OVF_W-1:0] v);
    return (v == {OVF_W{1'b1}}) ? v : v + OVF_W'(1);
  endfunction

endpackage

// File: rtl/dpram.sv
// Simple dual-port sample RAM: one write port, one registered read port.
// Latency: read data 1 cycle after raddr; same-address write returns old data.
// Backpressure: none, both ports accept every cycle.
module dpram #(
  parameter  int BITS = 16,
  parameter  int SIZE = 512,
  localparam int AW   = $clog2(SIZE)
) (
  input  logic            ck,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [BITS-1:0] wdata,
  input  logic [AW-1:0]   raddr,
  output logic [BITS-1:0] rdata
);

  logic [BITS-1:0] mem_q [SIZE];
  logic [BITS-1:0] rdata_q;

  // Write port and always-enabled registered read (read sees pre-write contents)
  always_ff @(posedge ck) begin
    if (we) mem_q[waddr] <= wdata;
    rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/audio_frame_buffer.sv
// Audio frame buffer: I2S samples captured per frame into RAM, engine kick/done handshake, host page control.
// Latency: iomem_ready 1 cycle after an accepted request; start 1 cycle after a frame's last sample; eng read 1 cycle.
// Backpressure: none on I2S or engine; host bus is held off only until iomem_valid has dropped after a transfer.
module audio_frame_buffer
  import audio_pkg::*;
#(
  parameter  logic [15:0] ADDR     = 16'h6000,
  parameter  int          CHANNELS = 16,
  parameter  int          FRAMES   = 32,
  parameter  int          SAMPLE_W = 16,
  localparam int          CHAN_W   = $clog2(CHANNELS),
  localparam int          FRAME_W  = $clog2(FRAMES),
  localparam int          AUDIO_W  = CHAN_W + FRAME_W
) (
  input  logic                ck,
  input  logic                rst,
  input  logic                iomem_valid,
  input  logic [3:0]          iomem_wstrb,
  input  logic [31:0]         iomem_addr,
  input  logic [31:0]         iomem_wdata,
  output logic                iomem_ready,
  output logic [31:0]         iomem_rdata,
  input  logic                in_valid,
  input  logic [CHAN_W-1:0]   in_chan,
  input  logic [SAMPLE_W-1:0] in_data,
  input  logic [AUDIO_W-1:0]  eng_raddr,
  output logic [SAMPLE_W-1:0] eng_rdata,
  output logic [FRAME_W-1:0]  frame,
  output logic                start,
  input  logic                done
);

  localparam logic [15:0] PG_STATUS_A = ADDR + PG_OFS_STATUS;
  localparam logic [15:0] PG_CLEAR_A  = ADDR + PG_OFS_CLEAR;
  localparam logic [15:0] PG_INPUT_A  = ADDR + PG_OFS_INPUT;

  logic [FRAME_W-1:0] wr_frame_q, wr_frame_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               busy_q, busy_d;
  logic               start_q, start_d;
  logic [OVF_W-1:0]   ovf_q, ovf_d;
  logic               run_q, run_d;
  logic               host_wr_q, host_wr_d;
  logic               iomem_ready_q, iomem_ready_d;
  logic [31:0]        iomem_rdata_q, iomem_rdata_d;
  logic               bus_busy_q, bus_busy_d;

  page_e              page;
  logic               accept, is_wr, st_wr, clr_wr, in_wr;
  logic               cap_we, host_we, frame_done;
  logic               ram_we;
  logic [AUDIO_W-1:0] ram_waddr;
  logic [31:0]        status_word;
  logic               unused_bits;

  // Page decode of the host address
  always_comb begin
    page = PG_NONE;
    if (iomem_addr[31:24] == IOMEM_SEG) begin
      if (iomem_addr[23:8] == PG_STATUS_A)     page = PG_STATUS;
      else if (iomem_addr[23:8] == PG_CLEAR_A) page = PG_CLEAR;
      else if (iomem_addr[23:8] == PG_INPUT_A) page = PG_INPUT;
    end
  end

  assign accept     = iomem_valid && (page != PG_NONE) && !bus_busy_q;
  assign is_wr      = (iomem_wstrb != 4'h0);
  assign st_wr      = accept && is_wr && (page == PG_STATUS);
  assign clr_wr     = accept && is_wr && (page == PG_CLEAR);
  assign in_wr      = accept && is_wr && (page == PG_INPUT);

  // host_wr picks exactly one RAM writer; the other source is dropped, never stalled
  assign cap_we     = in_valid && run_q && !host_wr_q;
  assign host_we    = in_wr && host_wr_q;
  assign frame_done = cap_we && (in_chan == CHAN_W'(CHANNELS - 1));
  assign ram_we     = host_wr_q ? host_we : cap_we;
  assign ram_waddr  = host_wr_q ? iomem_addr[AUDIO_W+1:2] : {wr_frame_q, in_chan};

  assign unused_bits = ^{iomem_addr[1:0], iomem_wdata[31:SAMPLE_W]};

  // STATUS read word assembled from live state
  always_comb begin
    status_word                             = '0;
    status_word[ST_OVF_LSB +: OVF_W]        = ovf_q;
    status_word[ST_FRAME_LSB +: FRAME_W]    = frame_q;
    status_word[ST_BUSY]                    = busy_q;
    status_word[ST_RUN]                     = run_q;
    status_word[ST_HOST_WR]                 = host_wr_q;
  end

  // Next-state: bus handshake, control bits, frame sequencing and engine handshake
  always_comb begin
    wr_frame_d    = wr_frame_q;
    frame_d       = frame_q;
    busy_d        = busy_q;
    start_d       = 1'b0;
    ovf_d         = ovf_q;
    run_d         = run_q;
    host_wr_d     = host_wr_q;
    iomem_ready_d = accept;
    iomem_rdata_d = (accept && !is_wr && page == PG_STATUS) ? status_word : 32'h0;
    bus_busy_d    = accept || (bus_busy_q && iomem_valid);

    if (st_wr) begin
      run_d     = iomem_wdata[1];
      host_wr_d = iomem_wdata[0];
    end

    if (done) busy_d = 1'b0;

    // A completed frame kicks the engine only if it is idle or finishing right now
    if (frame_done) begin
      frame_d    = wr_frame_q;
      wr_frame_d = wr_frame_q + FRAME_W'(1);
      if (!busy_q || done) begin
        start_d = 1'b1;
        busy_d  = 1'b1;
      end else begin
        ovf_d = sat_inc(ovf_q);
      end
    end

    if (clr_wr) begin
      wr_frame_d = '0;
      frame_d    = '0;
      busy_d     = 1'b0;
      start_d    = 1'b0;
      ovf_d      = '0;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge ck) begin
    if (rst) begin
      wr_frame_q    <= '0;
      frame_q       <= '0;
      busy_q        <= 1'b0;
      start_q       <= 1'b0;
      ovf_q         <= '0;
      run_q         <= 1'b0;
      host_wr_q     <= 1'b0;
      iomem_ready_q <= 1'b0;
      iomem_rdata_q <= 32'h0;
      bus_busy_q    <= 1'b0;
    end else begin
      wr_frame_q    <= wr_frame_d;
      frame_q       <= frame_d;
      busy_q        <= busy_d;
      start_q       <= start_d;
      ovf_q         <= ovf_d;
      run_q         <= run_d;
      host_wr_q     <= host_wr_d;
      iomem_ready_q <= iomem_ready_d;
      iomem_rdata_q <= iomem_rdata_d;
      bus_busy_q    <= bus_busy_d;
    end
  end

  dpram #(
    .BITS (SAMPLE_W),
    .SIZE (CHANNELS * FRAMES)
  ) u_ram (
    .ck    (ck),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (host_wr_q ? iomem_wdata[SAMPLE_W-1:0] : in_data),
    .raddr (eng_raddr),
    .rdata (eng_rdata)
  );

  assign iomem_ready = iomem_ready_q;
  assign iomem_rdata = iomem_rdata_q;
  assign frame       = frame_q;
  assign start       = start_q;

endmodule

// File: tb/tb_audio_frame_buffer.sv
// Self-checking bench for audio_frame_buffer against a frame-level reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_audio_frame_buffer;

  localparam int CH = 16;
  localparam int FR = 32;
  localparam logic [15:0] BASE = 16'h6000;
  localparam logic [15:0] OFS_STATUS = 16'h0200;
  localparam logic [15:0] OFS_CLEAR  = 16'h0300;
  localparam logic [15:0] OFS_INPUT  = 16'h0400;

  logic        ck = 1'b0;
  logic        rst;
  logic        iomem_valid;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic        iomem_ready;
  logic [31:0] iomem_rdata;
  logic        in_valid;
  logic [3:0]  in_chan;
  logic [15:0] in_data;
  logic [8:0]  eng_raddr;
  logic [15:0] eng_rdata;
  logic [4:0]  frame;
  logic        start;
  logic        done;

  int errors = 0;
  int checks = 0;

  // Reference model: what the block should hold, in frame-level terms
  logic [15:0] m_mem [CH*FR];
  bit          m_known [CH*FR];
  int          m_wrf, m_frame, m_ovf;
  bit          m_busy, m_run, m_host;

  always #5 ck = ~ck;

  audio_frame_buffer dut (
    .ck          (ck),
    .rst         (rst),
    .iomem_valid (iomem_valid),
    .iomem_wstrb (iomem_wstrb),
    .iomem_addr  (iomem_addr),
    .iomem_wdata (iomem_wdata),
    .iomem_ready (iomem_ready),
    .iomem_rdata (iomem_rdata),
    .in_valid    (in_valid),
    .in_chan     (in_chan),
    .in_data     (in_data),
    .eng_raddr   (eng_raddr),
    .eng_rdata   (eng_rdata),
    .frame       (frame),
    .start       (start),
    .done        (done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_status();
    return {8'h0, 8'(m_ovf), 3'h0, 5'(m_frame), 5'h0, m_busy, m_run, m_host};
  endfunction

  function automatic logic [31:0] mk_addr(input logic [15:0] ofs, input int idx);
    return {8'h03, BASE + ofs, 8'(idx * 4)};
  endfunction

  task automatic model_reset();
    m_wrf = 0; m_frame = 0; m_ovf = 0;
    m_busy = 0; m_run = 0; m_host = 0;
  endtask

  task automatic bus(input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] wdata,
                     output logic [31:0] rdata, output int lat);
    @(negedge ck);
    iomem_valid = 1'b1; iomem_addr = addr; iomem_wstrb = strb; iomem_wdata = wdata;
    lat = -1; rdata = 32'h0;
    for (int i = 0; i < 4 && lat < 0; i++) begin
      @(negedge ck);
      if (iomem_ready) begin lat = i; rdata = iomem_rdata; end
    end
    iomem_valid = 1'b0; iomem_wstrb = 4'h0;
    @(negedge ck);
    chk("ready_single_cycle", {31'h0, iomem_ready}, 32'h0);
  endtask

  task automatic host_wr(input logic [15:0] ofs, input int idx, input logic [31:0] d);
    logic [31:0] r;
    int lat;
    bus(mk_addr(ofs, idx), 4'hF, d, r, lat);
    chk("wr_ready_latency", lat, 0);
    if (ofs == OFS_STATUS) begin m_run = d[1]; m_host = d[0]; end
    if (ofs == OFS_CLEAR) begin m_wrf = 0; m_frame = 0; m_busy = 0; m_ovf = 0; end
    if (ofs == OFS_INPUT && m_host) begin m_mem[idx] = d[15:0]; m_known[idx] = 1; end
  endtask

  task automatic host_rd(input string tag, input logic [15:0] ofs, input logic [31:0] exp);
    logic [31:0] r;
    int lat;
    bus(mk_addr(ofs, 0), 4'h0, 32'h0, r, lat);
    chk({tag, "_latency"}, lat, 0);
    chk(tag, r, exp);
  endtask

  task automatic no_ready(input logic [31:0] addr);
    int cnt = 0;
    @(negedge ck);
    iomem_valid = 1'b1; iomem_addr = addr; iomem_wstrb = 4'h0;
    repeat (4) begin @(negedge ck); if (iomem_ready) cnt++; end
    iomem_valid = 1'b0;
    chk("unmatched_no_ready", cnt, 0);
  endtask

  task automatic eread(input int idx);
    @(negedge ck);
    eng_raddr = 9'(idx);
    @(negedge ck);
    chk("eng_rdata", {16'h0, eng_rdata}, {16'h0, m_mem[idx]});
  endtask

  task automatic pulse_done();
    @(negedge ck); done = 1'b1;
    @(negedge ck); done = 1'b0;
    m_busy = 0;
  endtask

  // One full frame of samples; chan 15 always last, others shuffled unless fixed
  task automatic frame_run(input bit done_last, input bit fixed, input bit chk_pulse);
    int order[CH];
    int spurious = 0;
    bit exp_start = 0;
    bit cap = m_run && !m_host;
    for (int i = 0; i < CH; i++) order[i] = i;
    if (!fixed)
      for (int i = CH - 2; i > 0; i--) begin
        int j = $urandom_range(i, 0);
        int t = order[i]; order[i] = order[j]; order[j] = t;
      end
    for (int i = 0; i < CH; i++) begin
      logic [15:0] d;
      @(negedge ck);
      if (start) spurious++;
      d = fixed ? 16'(16'h1000 + order[i]) : 16'($urandom);
      in_valid = 1'b1; in_chan = 4'(order[i]); in_data = d;
      done = (i == CH - 1) && done_last;
      if (cap) begin m_mem[m_wrf*CH + order[i]] = d; m_known[m_wrf*CH + order[i]] = 1; end
    end
    if (cap) begin
      m_frame = m_wrf;
      m_wrf = (m_wrf + 1) % FR;
      if (!m_busy || done_last) begin exp_start = 1; m_busy = 1; end
      else if (m_ovf < 255) m_ovf++;
    end else if (done_last) m_busy = 0;
    @(negedge ck);
    in_valid = 1'b0; done = 1'b0;
    chk("start", {31'h0, start}, {31'h0, exp_start});
    chk("frame", {27'h0, frame}, 32'(m_frame));
    if (chk_pulse) begin
      chk("no_early_start", spurious, 0);
      @(negedge ck);
      chk("start_width", {31'h0, start}, 32'h0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    int cnt;
    rst = 1'b1; iomem_valid = 0; iomem_wstrb = 0; iomem_addr = 0; iomem_wdata = 0;
    in_valid = 0; in_chan = 0; in_data = 0; eng_raddr = 0; done = 0;
    for (int i = 0; i < CH*FR; i++) begin m_known[i] = 0; m_mem[i] = 16'h0; end
    model_reset();
    repeat (3) @(negedge ck);
    chk("rst_ready", {31'h0, iomem_ready}, 32'h0);
    chk("rst_rdata", iomem_rdata, 32'h0);
    chk("rst_start", {31'h0, start}, 32'h0);
    chk("rst_frame", {27'h0, frame}, 32'h0);
    rst = 1'b0;
    host_rd("status_after_reset", OFS_STATUS, 32'h0);

    // Address decode misses
    no_ready({8'h03, 16'h6100, 8'h00});
    no_ready({8'h02, 16'h6200, 8'h00});
    no_ready({8'h03, 16'h6500, 8'h00});

    // Held valid yields one ready only
    @(negedge ck);
    iomem_valid = 1'b1; iomem_addr = mk_addr(OFS_STATUS, 0); iomem_wstrb = 4'h0;
    cnt = 0;
    repeat (5) begin @(negedge ck); if (iomem_ready) cnt++; end
    iomem_valid = 1'b0;
    chk("held_valid_single_ready", cnt, 1);
    @(negedge ck);

    // First frame with known data
    host_wr(OFS_STATUS, 0, 32'h2);
    frame_run(1'b0, 1'b1, 1'b1);
    eread(5);
    chk("eng_rdata_0x1005", {16'h0, eng_rdata}, 32'h1005);
    host_rd("status_frame0", OFS_STATUS, exp_status());
    pulse_done();

    // 32 more frames, each acknowledged, frame index wraps
    for (int k = 0; k < FR; k++) begin
      frame_run(1'b0, 1'b0, 1'b1);
      eread(m_frame*CH + $urandom_range(CH-1, 0));
      pulse_done();
      if (k == 19) host_rd("status_frame20", OFS_STATUS, exp_status());
    end
    chk("frame_wrapped", {27'h0, frame}, 32'h0);
    host_rd("status_after_wrap", OFS_STATUS, exp_status());

    // Overrun: engine never finishes
    host_wr(OFS_CLEAR, 0, 32'h0);
    frame_run(1'b0, 1'b0, 1'b1);
    frame_run(1'b0, 1'b0, 1'b1);
    host_rd("status_ovf1", OFS_STATUS, exp_status());
    chk("model_ovf1", exp_status(), 32'h0001_0106);
    repeat (300) frame_run(1'b0, 1'b0, 1'b0);
    host_rd("status_ovf_sat", OFS_STATUS, exp_status());

    // done coinciding with frame completion
    host_wr(OFS_CLEAR, 0, 32'h0);
    frame_run(1'b0, 1'b0, 1'b1);
    frame_run(1'b1, 1'b0, 1'b1);
    host_rd("status_done_coincide", OFS_STATUS, exp_status());
    frame_run(1'b0, 1'b0, 1'b1);
    host_rd("status_busy_held", OFS_STATUS, exp_status());

    // Host writes while I2S strobes are ignored
    pulse_done();
    host_wr(OFS_STATUS, 0, 32'h1);
    @(negedge ck);
    in_valid = 1'b1; in_chan = 4'd3; in_data = 16'h5555;
    host_wr(OFS_INPUT, 7, 32'h0000_BEEF);
    in_valid = 1'b0;
    eread(7);
    if (m_known[m_wrf*CH + 3]) eread(m_wrf*CH + 3);
    for (int k = 0; k < 6; k++) begin
      int idx = $urandom_range(63, 0);
      host_wr(OFS_INPUT, idx, $urandom);
      eread(idx);
    end
    host_rd("input_read_zero", OFS_INPUT, 32'h0);
    host_rd("clear_read_zero", OFS_CLEAR, 32'h0);
    host_rd("status_host_mode", OFS_STATUS, exp_status());

    // Host write discarded when host_wr=0
    host_wr(OFS_STATUS, 0, 32'h2);
    host_wr(OFS_INPUT, 9, 32'h0000_DEAD);
    eread(9);

    // Reset in the middle of a frame
    host_wr(OFS_CLEAR, 0, 32'h0);
    for (int c = 0; c <= 8; c++) begin
      logic [15:0] d = 16'($urandom);
      @(negedge ck);
      in_valid = 1'b1; in_chan = 4'(c); in_data = d;
      m_mem[c] = d; m_known[c] = 1;
    end
    @(negedge ck);
    in_valid = 1'b0; rst = 1'b1;
    cnt = 0;
    repeat (3) begin @(negedge ck); if (start) cnt++; end
    rst = 1'b0;
    model_reset();
    chk("midframe_rst_no_start", cnt, 0);
    chk("midframe_rst_frame", {27'h0, frame}, 32'h0);
    host_rd("status_after_midframe_rst", OFS_STATUS, 32'h0);
    eread(4);
    host_wr(OFS_STATUS, 0, 32'h2);
    frame_run(1'b0, 1'b0, 1'b1);
    host_rd("status_after_restart", OFS_STATUS, exp_status());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/audio_frame_buffer.md
AUDIO_FRAME_BUFFER -- requirements
Module: audio_frame_buffer

Interface
REQ-001 SHALL have parameter ADDR, default 16'h6000, bus page base.
REQ-002 SHALL have parameter CHANNELS, default 16, channels per frame; must be a power of two.
REQ-003 SHALL have parameter FRAMES, default 32, frames held; must be a power of two.
REQ-004 SHALL have parameter SAMPLE_W, default 16, sample width.
REQ-005 SHALL derive CHAN_W=clog2(CHANNELS), FRAME_W=clog2(FRAMES) and AUDIO_W=CHAN_W+FRAME_W.
REQ-006 SHALL have port ck, input, 1, the single clock; all logic on posedge.
REQ-007 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-008 SHALL have ports iomem_valid in 1, iomem_wstrb in 4, iomem_addr in 32 and iomem_wdata in 32: host bus request.
REQ-009 SHALL have ports iomem_ready out 1 and iomem_rdata out 32: host bus response.
REQ-010 SHALL have ports in_valid in 1, in_chan in CHAN_W and in_data in SAMPLE_W: I2S receive sample strobe.
REQ-011 SHALL have ports eng_raddr in AUDIO_W and eng_rdata out SAMPLE_W: engine read port.
REQ-012 SHALL have ports frame out FRAME_W (last completed frame), start out 1 (frame-ready pulse) and done in 1 (engine finished).

Function
REQ-013 SHALL decode pages on iomem_addr[31:24]==8'h03 and iomem_addr[23:8] equal to one of the following: STATUS=ADDR+16'h0200, CLEAR=ADDR+16'h0300 or INPUT=ADDR+16'h0400.
REQ-014 SHALL pulse iomem_ready for exactly one cycle, one cycle after iomem_valid plus a page match, then ignore iomem_valid until it has been low for one cycle.
REQ-015 SHALL give no ready for unmatched addresses and SHALL drive iomem_rdata to 0 except in the ready cycle of a STATUS read.
REQ-016 SHALL treat a transfer as a write when iomem_wstrb!=0; otherwise it is a read.
REQ-017 SHALL return the STATUS read word {8'h0, ovf[7:0], 3'h0, frame (bits 12:8, zero-extended), 5'h0, busy (bit 2), run (bit 1), host_wr (bit 0)}.
REQ-018 SHALL load run and host_wr from iomem_wdata[1:0] on a STATUS write.
REQ-019 SHALL clear wr_frame, frame, busy, start and ovf on a CLEAR write, keep control bits unchanged, and return 0 on a CLEAR read.
REQ-020 SHALL, on an INPUT write with host_wr=1, write iomem_wdata[SAMPLE_W-1:0] to RAM word iomem_addr[AUDIO_W+1:2]; with host_wr=0, acknowledge and discard. INPUT reads SHALL return 0.
REQ-021 SHALL, on in_valid with run=1 and host_wr=0, write in_data to RAM address {wr_frame, in_chan}; otherwise ignore in_valid.
REQ-022 SHALL, on a capture write with in_chan==CHANNELS-1, set frame<=wr_frame and wr_frame<=wr_frame+1 (FRAMES-1 wraps to 0) at that edge.
REQ-023 SHALL register a frame-complete event and pulse start for exactly one cycle in the following cycle if busy=0 or done=1, then set busy=1.
REQ-024 SHALL, on a frame-complete event with busy=1 and done=0, suppress start, still advance frame, and increment ovf, saturating at 255.
REQ-025 SHALL clear busy on done; when done and start coincide, busy SHALL remain 1.
REQ-026 SHALL make eng_rdata the RAM word at eng_raddr registered one cycle earlier (latency 1, always enabled); a same-address write in the same cycle returns the old data.
REQ-027 SHALL not block host and I2S RAM writes against each other; host_wr gates exclusively which source writes.

Reset
REQ-028 SHALL, while rst=1, clear wr_frame, frame, busy, start, ovf, run, host_wr, iomem_ready, iomem_rdata and the bus idle state.
REQ-029 SHALL, on reset mid-frame, discard the partial frame without start; RAM contents are not cleared.
REQ-030 SHALL make eng_rdata undefined until the first read after reset.

Structure
REQ-031 SHALL place page offsets (16'h0200/0300/0400), STATUS bit positions and the ovf width in shared package audio_pkg.
REQ-032 SHALL implement sample storage as one instance of the existing dpram (BITS=SAMPLE_W, SIZE=CHANNELS*FRAMES); all other logic is in this module.

Verification
REQ-033 SHALL test this scenario: STATUS write 0x2, then 16 in_valid with chans 0..15 and data 0x1000+chan -> frame=0, single start one cycle after chan 15, eng_raddr 5 reads 0x1005 next cycle.
REQ-034 SHALL test this scenario: 32 full frames with done returned each time -> frame wraps 31->0, ovf=0, STATUS read shows frame in bits 12:8.
REQ-035 SHALL test this scenario: two frames with no done -> second start suppressed, STATUS ovf=1, busy=1; 300 overruns -> ovf=255.
REQ-036 SHALL test this scenario: STATUS write 0x1, INPUT write 0xBEEF to addr ADDR+0x0400+4*7 while in_valid is active -> RAM[7]=0xBEEF, I2S sample ignored.
REQ-037 SHALL test this scenario: rst asserted after chan 8 of a frame -> no start, frame=0, STATUS reads 0; unmatched address -> no iomem_ready.
REQ-038 SHALL test this scenario: done and frame-complete in the same cycle -> start pulses, busy stays 1, ovf unchanged.
